timer_obi_arbiter: RTL
======================

Name: timer_obi_arbiter

Overview:
- Two-master OBI arbiter in front of the timer peripheral's OBI slave port; lets the core data port (master 0) and the debug module (master 1) share the timer register file.
- Arbitration is round-robin.
- A small in-order ID FIFO records which master owns each outstanding transfer, so every slave response returns to the master that issued it.
- Sits between the bus crossbar and the timer slave. The slave grants combinationally and answers with rvalid in a later cycle.

Parameters:
- MAX_OUTSTANDING, 2, depth of the owner-ID FIFO; maximum accepted-but-unanswered transfers (power of two, >=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- m0_req_i / m1_req_i  in  1  master request
- m0_we_i / m1_we_i  in  1  write enable
- m0_be_i / m1_be_i  in  4  byte enables
- m0_addr_i / m1_addr_i  in  32  address
- m0_data_i / m1_data_i  in  32  write data
- m0_gnt_o / m1_gnt_o  out  1  grant to master
- m0_rvalid_o / m1_rvalid_o  out  1  response valid to master
- m0_data_o / m1_data_o  out  32  read data to master
- s_req_o  out  1  request to timer slave
- s_we_o  out  1  write enable to slave
- s_be_o  out  4  byte enables to slave
- s_addr_o  out  32  address to slave
- s_data_o  out  32  write data to slave
- s_gnt_i  in  1  slave grant
- s_rvalid_i  in  1  slave response valid
- s_data_i  in  32  slave read data
- busy_o  out  1  at least one transfer outstanding
- err_o  out  1  sticky: response arrived with no owner recorded

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - FIFO emptied; busy_o=0; err_o=0.
  - Priority pointer set to "master 1 last granted", so master 0 wins the first contention.
  - Outputs are combinational from these registers, so after reset all m*_gnt_o, m*_rvalid_o and s_req_o are 0 unless an input request is present.
- Selection is combinational:
  - Exactly one master requesting: that master is selected.
  - Both requesting: the master not granted last is selected.
  - Neither requesting: no selection; s_req_o=0.
- s_req_o = (m0_req_i | m1_req_i) & !full.
- s_we_o, s_be_o, s_addr_o and s_data_o mux from the selected master. They are 0 when no master is selected.
- mX_gnt_o = s_gnt_i & s_req_o & (selected==X). At most one grant is high per cycle.
- Accept means s_req_o & s_gnt_i. On accept:
  - the selected master's ID is pushed into the FIFO;
  - the priority pointer updates to that master.
  - The pointer never changes without an accept.
- FIFO full (MAX_OUTSTANDING entries): s_req_o forced 0 and no grants. The request is held off, never dropped.
- Response path:
  - On s_rvalid_i, the head ID is popped.
  - rvalid is asserted only to the head master, in the same cycle (zero added latency).
  - s_data_i is forwarded to both m0_data_o and m1_data_o; it is meaningful only where rvalid=1.
- Push and pop in the same cycle: occupancy unchanged. This includes the full case, since pop does not enable push in that cycle (no full-bypass).
- s_rvalid_i with FIFO empty:
  - no rvalid to either master;
  - err_o set and held until reset;
  - FIFO pointers unchanged.
- busy_o = FIFO non-empty (registered occupancy).
- Responses return strictly in accept order. The timer slave answers in order, one cycle after accept.
- A master deasserting req_i before it is granted is legal. Nothing is recorded for it.
- Reset asserted mid-transfer: outstanding IDs are discarded. Any later stray s_rvalid_i sets err_o.

Test Plan:
- Single master: m0 read at addr 0x0000_0004, slave grants at once and returns 0x1234 next cycle -> m0_gnt_o=1 in cycle 0; m0_rvalid_o=1 with m0_data_o=0x1234 in cycle 1; m1_rvalid_o stays 0; busy_o pulses 1 for one cycle.
- Contention after reset: m0 and m1 request continuously for 4 cycles -> grants alternate m0, m1, m0, m1. Each rvalid goes to the master granted in the previous cycle.
- Backpressure: s_gnt_i=0 for 3 cycles, then 1, with m1 writing 0xDEAD_BEEF to 0x8, be=0xF -> s_req_o=1 and s_addr_o/s_data_o/s_be_o stable for all 4 cycles; m1_gnt_o=1 only in cycle 3.
- FIFO full, MAX_OUTSTANDING=2, slave withholds rvalid -> two accepts, then s_req_o=0 despite m0_req_i=1. One s_rvalid_i pops the first owner; the next cycle grants again.
- Stray response: s_rvalid_i=1 with FIFO empty -> no master rvalid; err_o=1 and stays 1 until rst_i. A reset issued with 1 entry outstanding gives busy_o=0 next cycle.

Source files
------------

// File: rtl/timer_obi_arbiter.sv
// Round-robin arbiter letting two OBI masters share the timer slave port.
// An in-order owner FIFO steers each slave response back to its issuing master.
module timer_obi_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_data_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_data_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  logic             owner_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             last_gnt_q;  // 1 = master 1 was granted most recently
  logic             err_q;

  logic any_req;
  logic sel;
  logic full;
  logic empty;
  logic accept;
  logic pop;
  logic stray;
  logic head;

  // Handshake: a request is accepted in the cycle where s_req_o and s_gnt_i are
  // both high; the slave answers each accepted request with exactly one
  // s_rvalid_i pulse in a later cycle, in accept order. Masters may withdraw a
  // request that has not yet been granted.
  assign any_req = m0_req_i | m1_req_i;
  assign sel     = (m0_req_i & m1_req_i) ? ~last_gnt_q : m1_req_i;
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign s_req_o = any_req & ~full;
  assign accept  = s_req_o & s_gnt_i;
  assign pop     = s_rvalid_i & ~empty;
  assign stray   = s_rvalid_i & empty;
  assign head    = owner_q[rd_ptr_q];

  always_comb begin
    s_we_o   = 1'b0;
    s_be_o   = '0;
    s_addr_o = '0;
    s_data_o = '0;
    if (any_req) begin
      if (sel) begin
        s_we_o   = m1_we_i;
        s_be_o   = m1_be_i;
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
      end else begin
        s_we_o   = m0_we_i;
        s_be_o   = m0_be_i;
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
      end
    end
  end

  assign m0_gnt_o    = accept & ~sel;
  assign m1_gnt_o    = accept & sel;
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_data_o   = s_data_i;
  assign m1_data_o   = s_data_i;
  assign busy_o      = ~empty;
  assign err_o       = err_q;

  // Owner storage needs no reset: entries are only read while count_q says valid.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      owner_q[wr_ptr_q] <= sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_gnt_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q   <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        last_gnt_q <= sel;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !accept) begin
        count_q <= count_q - 1'b1;
      end
      if (stray) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
